// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue sequencer: opcode constants,
// instruction field positions, flag bit indices and FSM state encoding.
package alu_issue_pkg;

    // Instruction layout: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] mode
    localparam int INSTR_W  = 16;
    localparam int OPC_LSB  = 12;
    localparam int RD_LSB   = 9;
    localparam int RS1_LSB  = 6;
    localparam int RS2_LSB  = 3;
    localparam int MODE_LSB = 0;

    // Flag vector bit positions
    localparam int CARRY    = 0;
    localparam int SIGN     = 1;
    localparam int OVERFLOW = 2;
    localparam int ZERO     = 3;

    // Opcodes understood by the downstream ALU
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADC  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SBB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_SAR  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_NOT  = 4'b1011;
    localparam logic [3:0] OP_CMP  = 4'b1100;
    localparam logic [3:0] OP_INC  = 4'b1101;
    localparam logic [3:0] OP_DEC  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Compare only updates flags; every other opcode writes its destination.
    function automatic logic writes_reg(input logic [3:0] op);
        return op != OP_CMP;
    endfunction

endpackage

// File: rtl/alu_issue_rf.sv
// 2^REGS_CODING x WIDTH register file: two asynchronous read ports for
// operand fetch, a single write port shared by preload and writeback,
// and a registered debug read port.
module alu_issue_rf #(
    parameter int WIDTH       = 32,
    parameter int REGS_CODING = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_en,
    input  logic [REGS_CODING-1:0] ld_addr,
    input  logic [WIDTH-1:0]       ld_data,
    input  logic                   wb_en,
    input  logic [REGS_CODING-1:0] wb_addr,
    input  logic [WIDTH-1:0]       wb_data,
    input  logic [REGS_CODING-1:0] rs1_addr,
    output logic [WIDTH-1:0]       rs1_data,
    input  logic [REGS_CODING-1:0] rs2_addr,
    output logic [WIDTH-1:0]       rs2_data,
    input  logic [REGS_CODING-1:0] dbg_addr,
    output logic [WIDTH-1:0]       dbg_data
);

    localparam int NREGS = 1 << REGS_CODING;

    logic [WIDTH-1:0] regs [NREGS];

    // Single write port; preload and writeback never coincide (IDLE vs WB),
    // writeback is given priority anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end else if (ld_en) begin
            regs[ld_addr] <= ld_data;
        end
    end

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    // Debug read is registered: data appears one cycle after the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= regs[dbg_addr];
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback sequencer for a combinational ALU. Accepts instructions
// and register preloads in IDLE, fetches operands (READ), drives the ALU
// (EXEC) and writes result/flags back (WB). Every instruction takes four
// cycles.
// Handshake rule: a transfer happens on a rising edge where both valid and
// ready are high; ready depends only on FSM state, never on valid.
// Optional feature macro: ALU_ISSUE_IMM_EN (mode[0]=1 takes the rs2 field as
// a zero-extended immediate for op2).
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int OPCODE      = 4,
    parameter int REGS_CODING = 3,
    parameter int FLAGS       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [15:0]            instr,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [REGS_CODING-1:0] ld_addr,
    input  logic [WIDTH-1:0]       ld_data,
    input  logic [REGS_CODING-1:0] rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   alu_en,
    output logic [OPCODE-1:0]      alu_opcode,
    output logic [WIDTH-1:0]       alu_op1,
    output logic [WIDTH-1:0]       alu_op2,
    output logic                   alu_cin,
    output logic [REGS_CODING-1:0] alu_dest,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic [FLAGS-1:0]       alu_flags,
    input  logic [REGS_CODING-1:0] alu_dest_ret,
    output logic [FLAGS-1:0]       flags,
    output logic                   done,
    output logic [1:0]             fsm_state
);

    state_t state, state_next;

    // Fields latched at the instruction handshake
    logic [OPCODE-1:0]      opcode_l;
    logic [REGS_CODING-1:0] rd_l, rs1_l, rs2_l;

    // Operand registers; they also drive the ALU and hold between issues
    logic [OPCODE-1:0]      opcode_q;
    logic [WIDTH-1:0]       op1_q, op2_q;
    logic [REGS_CODING-1:0] dest_q;
    logic                   cin_q;

    // Writeback registers captured at the end of EXEC
    logic [WIDTH-1:0]       wb_result;
    logic [FLAGS-1:0]       wb_flags;
    logic [REGS_CODING-1:0] wb_dest;
    logic                   wb_writes;

    logic [FLAGS-1:0]       flags_q;
    logic [WIDTH-1:0]       rs1_data, rs2_data, op2_sel;
    logic                   instr_fire, ld_fire, wb_en;
    logic                   unused_mode;

    assign unused_mode = ^instr[MODE_LSB +: 3];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        ld_ready    = 1'b0;
        alu_en      = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                ld_ready    = 1'b1;
                if (instr_valid) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: begin
                alu_en     = 1'b1;
                state_next = ST_WB;
            end
            ST_WB: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign instr_fire = instr_valid & instr_ready;
    assign ld_fire    = ld_valid & ld_ready;
    assign wb_en      = (state == ST_WB) & wb_writes;
    assign fsm_state  = state;

`ifdef ALU_ISSUE_IMM_EN
    logic imm_l;

    // Remember whether op2 comes from the rs2 field itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_l <= 1'b0;
        end else if (instr_fire) begin
            imm_l <= instr[MODE_LSB];
        end
    end

    assign op2_sel = imm_l ? {{(WIDTH-REGS_CODING){1'b0}}, rs2_l} : rs2_data;
`else
    assign op2_sel = rs2_data;
`endif

    // Latch instruction fields on the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_l <= '0;
            rd_l     <= '0;
            rs1_l    <= '0;
            rs2_l    <= '0;
        end else if (instr_fire) begin
            opcode_l <= instr[OPC_LSB +: OPCODE];
            rd_l     <= instr[RD_LSB  +: REGS_CODING];
            rs1_l    <= instr[RS1_LSB +: REGS_CODING];
            rs2_l    <= instr[RS2_LSB +: REGS_CODING];
        end
    end

    // Operand fetch at the end of READ; a preload taken with the handshake
    // is already in the file by then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            dest_q   <= '0;
            cin_q    <= 1'b0;
        end else if (state == ST_READ) begin
            opcode_q <= opcode_l;
            op1_q    <= rs1_data;
            op2_q    <= op2_sel;
            dest_q   <= rd_l;
            cin_q    <= flags_q[CARRY];
        end
    end

    assign alu_opcode = opcode_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_cin    = cin_q;
    assign alu_dest   = dest_q;

    // Capture the ALU return at the end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_result <= '0;
            wb_flags  <= '0;
            wb_dest   <= '0;
            wb_writes <= 1'b0;
        end else if (state == ST_EXEC) begin
            wb_result <= alu_result;
            wb_flags  <= alu_flags;
            wb_dest   <= alu_dest_ret;
            wb_writes <= writes_reg(opcode_q);
        end
    end

    // Architectural flags update on every retiring instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (state == ST_WB) begin
            flags_q <= wb_flags;
        end
    end

    assign flags = flags_q;

    alu_issue_rf #(
        .WIDTH       (WIDTH),
        .REGS_CODING (REGS_CODING)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (ld_fire),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_dest),
        .wb_data  (wb_result),
        .rs1_addr (rs1_l),
        .rs1_data (rs1_data),
        .rs2_addr (rs2_l),
        .rs2_data (rs2_data),
        .dbg_addr (rd_addr),
        .dbg_data (rd_data)
    );

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: an ALU stub answers the DUT's ALU drive, a
// reference model of the register file and flags predicts each retired
// instruction, and a monitor checks done timing, flags and the written
// register against the expected queues.
module tb_alu_issue;

    localparam logic [3:0] T_ADD = 4'd0;
    localparam logic [3:0] T_ADC = 4'd1;
    localparam logic [3:0] T_SUB = 4'd2;
    localparam logic [3:0] T_SHL = 4'd7;
    localparam logic [3:0] T_CMP = 4'd12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [2:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        alu_en;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_op1, alu_op2;
    logic        alu_cin;
    logic [2:0]  alu_dest;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [2:0]  alu_dest_ret;
    logic [3:0]  flags;
    logic        done;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference state
    logic [31:0] m_regs [8];
    logic [3:0]  m_flags;

    // Scoreboard queues, one entry per retiring instruction
    logic [31:0] exp_q[$];
    logic [3:0]  exp_flags_q[$];
    logic [2:0]  exp_rd_q[$];
    int          exp_cyc_q[$];

    logic        mon_busy = 1'b0;
    logic [2:0]  mon_addr = '0;
    logic [2:0]  dbg_addr = '0;

    assign rd_addr = mon_busy ? mon_addr : dbg_addr;

    alu_issue dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .alu_en       (alu_en),
        .alu_opcode   (alu_opcode),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_cin      (alu_cin),
        .alu_dest     (alu_dest),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .alu_dest_ret (alu_dest_ret),
        .flags        (flags),
        .done         (done),
        .fsm_state    (fsm_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {ZERO, OVERFLOW, SIGN, CARRY, result}
    function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin);
        logic [32:0] w;
        logic [31:0] r;
        logic [31:0] bb;
        logic        v;
        w  = 33'd0;
        v  = 1'b0;
        bb = (op == 4'd13 || op == 4'd14) ? 32'd1 : b;
        case (op)
            4'd0, 4'd13: w = {1'b0, a} + {1'b0, bb};
            4'd1:        w = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            4'd2, 4'd12, 4'd14: w = {1'b0, a} - {1'b0, bb};
            4'd3:        w = {1'b0, a} - {1'b0, b} - {32'd0, cin};
            default:     w = 33'd0;
        endcase
        r = w[31:0];
        case (op)
            4'd0, 4'd1, 4'd13:        v = (a[31] == bb[31]) && (r[31] != a[31]);
            4'd2, 4'd3, 4'd12, 4'd14: v = (a[31] != bb[31]) && (r[31] != a[31]);
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = a << b[4:0];
            4'd8:  r = a >> b[4:0];
            4'd9:  r = $signed(a) >>> b[4:0];
            4'd10: r = a * b;
            4'd11: r = ~a;
            4'd15: r = a;
            default: ;
        endcase
        return {(r == 32'd0), v, r[31], w[32], r};
    endfunction

    // ALU stub answering the DUT
    always_comb begin
        {alu_flags, alu_result} = alu_model(alu_opcode, alu_op1, alu_op2, alu_cin);
        alu_dest_ret = alu_dest;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_flags = 4'd0;
    endtask

    // Driver: register preload
    task automatic load(input logic [2:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        n = 0;
        while (!ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ld_ready) begin
            fail_now("ld_ready_wait");
            ld_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        m_regs[a] = d;
    endtask

    // Driver: instruction issue, optionally with a same-cycle preload
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [2:0] mode, input bit with_ld,
                         input logic [2:0] la, input logic [31:0] ldv, input bit retire);
        int n;
        logic [31:0] a, b;
        logic [35:0] res;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {op, rd, rs1, rs2, mode};
        if (with_ld) begin
            ld_valid = 1'b1;
            ld_addr  = la;
            ld_data  = ldv;
        end
        n = 0;
        while (!(instr_ready && (!with_ld || ld_ready)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            fail_now("instr_ready_wait");
            instr_valid = 1'b0;
            ld_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        ld_valid = 1'b0;
        if (with_ld) m_regs[la] = ldv;
        if (!retire) return;
        a = m_regs[rs1];
`ifdef ALU_ISSUE_IMM_EN
        b = mode[0] ? {29'd0, rs2} : m_regs[rs2];
`else
        b = m_regs[rs2];
`endif
        res = alu_model(op, a, b, m_flags[0]);
        m_flags = res[35:32];
        if (op != T_CMP) m_regs[rd] = res[31:0];
        exp_q.push_back(m_regs[rd]);
        exp_flags_q.push_back(m_flags);
        exp_rd_q.push_back(rd);
        exp_cyc_q.push_back(cyc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || mon_busy) fail_now("drain");
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: each done pulse retires the oldest expected instruction
    initial begin
        logic [31:0] ev;
        logic [3:0]  ef;
        int          ec;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    ef = exp_flags_q.pop_front();
                    mon_addr = exp_rd_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    mon_busy = 1'b1;
                    // handshake edge N -> done seen after edge N+2, sampled at N+3
                    check("done_latency", 32'(cyc), 32'(ec + 2));
                    @(posedge clk);
                    #1;
                    check("flags", {28'd0, flags}, {28'd0, ef});
                    @(posedge clk);
                    #1;
                    check("reg_value", rd_data, ev);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_instr_ready", 32'(instr_ready), 32'd1);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_op1", alu_op1, 32'd0);
        check("rst_alu_op2", alu_op2, 32'd0);
        check("rst_alu_cin", 32'(alu_cin), 32'd0);
        check("rst_alu_dest", 32'(alu_dest), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        rst = 1'b0;

        // Basic add: R3 = 5 + 7
        load(3'd1, 32'd5);
        load(3'd2, 32'd7);
        issue(T_ADD, 3'd3, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1);
        drain();
        check("add_flags", 32'(flags), 32'h0);

        // Wrap to zero sets CARRY and ZERO; ADC then consumes the carry
        load(3'd1, 32'hFFFF_FFFF);
        load(3'd2, 32'd1);
        issue(T_ADD, 3'd4, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1);
        drain();
        check("wrap_flags", 32'(flags), 32'h9);
        issue(T_ADC, 3'd5, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1);
        drain();
        check("adc_flags", 32'(flags), 32'h0);

        // Compare writes flags only
        load(3'd1, 32'd9);
        load(3'd2, 32'd9);
        load(3'd6, 32'h0000_00AA);
        issue(T_CMP, 3'd6, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1);
        drain();
        check("cmp_flags", 32'(flags), 32'h8);

        // Preload accepted with the instruction is seen by its operand read
        load(3'd2, 32'd4);
        issue(T_SUB, 3'd1, 3'd1, 3'd2, 3'd0, 1'b1, 3'd1, 32'd20, 1'b1);
        drain();

        // Immediate mode (register mode when the feature is not built)
        load(3'd1, 32'd10);
        issue(T_SHL, 3'd2, 3'd1, 3'd3, 3'd1, 1'b0, 3'd0, 32'd0, 1'b1);
        drain();

        // Same register as both sources and destination
        load(3'd7, 32'd21);
        issue(T_ADD, 3'd7, 3'd7, 3'd7, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1);

        // Random mix of preloads, instructions and combined handshakes
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: load(3'($urandom_range(0, 7)), rnd_val());
                3: issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                         3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                         3'($urandom_range(0, 7)), 1'b1, 3'($urandom_range(0, 7)),
                         rnd_val(), 1'b1);
                default: issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                               3'($urandom_range(0, 7)), 1'b0, 3'd0, 32'd0, 1'b1);
            endcase
        end
        drain();

        // Reset during EXEC discards the instruction
        load(3'd1, 32'd3);
        load(3'd2, 32'd4);
        issue(T_ADD, 3'd3, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0);
        @(posedge clk);
        #2;
        check("exec_before_rst", 32'(alu_en), 32'd1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_state", 32'(fsm_state), 32'd0);
        check("post_rst_instr_ready", 32'(instr_ready), 32'd1);
        dbg_addr = 3'd3;
        @(posedge clk);
        #1;
        check("post_rst_r3", rd_data, 32'd0);
        repeat (5) @(negedge clk);
        check("post_rst_flags", 32'(flags), 32'd0);

        // Recovery after reset
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 0) load(3'($urandom_range(0, 7)), rnd_val());
            issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'b0, 3'd0, 32'd0, 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
